// File: rtl/ram_pkg.sv
// Shared types and constants for the parametrised data-path RAM.
package ram_pkg;

    // Controller states: CLEAR zero-fills the array, READY serves requests.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_t;

    // Read-during-write policy selectors for the RDW_MODE parameter.
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

endpackage : ram_pkg

// File: rtl/ram_clear_fsm.sv
// Post-reset clear sequencer: walks clr_addr through 0..DEPTH-1,
// issuing one zero write per cycle, then parks in READY.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  CLEAR | zero-filling mem[clr_addr]; busy high, requests ignored
//  READY | array usable; counter idle
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ram_state_t        r_state;
    ram_state_t        w_next;
    logic [ADDR_W-1:0] r_clr_addr;
    logic              w_last;

    assign w_last = (r_clr_addr == LAST_ADDR);

    // State register; the reset state depends on whether clearing is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= enable ? CLEAR : READY;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: leave CLEAR once the final word has been written.
    always_comb begin
        w_next = r_state;
        case (r_state)
            CLEAR:   if (w_last) w_next = READY;
            READY:   w_next = READY;
            default: w_next = READY;
        endcase
    end

    // Clear address counter, restarts from zero on every reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_addr <= '0;
        end else if (r_state == CLEAR && !w_last) begin
            r_clr_addr <= r_clr_addr + 1'b1;
        end
    end

    assign busy     = (r_state == CLEAR);
    assign clr_we   = (r_state == CLEAR);
    assign clr_addr = r_clr_addr;

endmodule : ram_clear_fsm

// File: rtl/ram_param.sv
// Parametrised single-port synchronous RAM with registered read,
// selectable read-during-write policy, range checking and post-reset clear.
module ram_param
    import ram_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 8,
    parameter int DEPTH          = 256,
    parameter int RDW_MODE       = RDW_OLD,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic              re,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rvalid,
    output logic              busy,
    output logic              err
);

    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_data_out;
    logic              r_rvalid;
    logic              r_err;
    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_in_range;

    assign w_in_range = ({1'b0, addr} < DEPTH_EXT);

    ram_clear_fsm #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (CLEAR_ON_RESET != 0),
        .busy     (w_busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    // Array write port; the clear sequencer has priority and the array is never reset.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (we && w_in_range) begin
            r_mem[addr] <= data_in;
        end
    end

    // Registered read data, valid strobe and range-error strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out <= '0;
            r_rvalid   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            if (!w_busy) begin
                if (re) begin
                    r_rvalid <= 1'b1;
                    if (!w_in_range) begin
                        r_data_out <= '0;
                    end else if (we && RDW_MODE == RDW_NEW) begin
                        r_data_out <= data_in;
                    end else begin
                        r_data_out <= r_mem[addr];
                    end
                end
                if ((we || re) && !w_in_range) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign data_out = r_data_out;
    assign rvalid   = r_rvalid;
    assign err      = r_err;
    assign busy     = w_busy;

endmodule : ram_param

// File: tb/tb_ram_param.sv
// Bench for ram_param: three configurations share one stimulus stream and
// are checked every cycle against a rule-level model, plus literal checks.
module tb_ram_param;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      addr  = '0;
    logic [7:0]      din   = '0;
    logic            we    = 1'b0;
    logic            re    = 1'b0;
    logic [2:0][7:0] dout;
    logic [2:0]      rv;
    logic [2:0]      bz;
    logic [2:0]      er;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Instance 0: defaults. Instance 1: DEPTH=200, write-first. Instance 2: no clear.
    ram_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u0 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .we(we), .re(re), .data_in(din),
        .data_out(dout[0]), .rvalid(rv[0]), .busy(bz[0]), .err(er[0]));
    ram_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u1 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .we(we), .re(re), .data_in(din),
        .data_out(dout[1]), .rvalid(rv[1]), .busy(bz[1]), .err(er[1]));
    ram_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .RDW_MODE(0), .CLEAR_ON_RESET(0)) u2 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .we(we), .re(re), .data_in(din),
        .data_out(dout[2]), .rvalid(rv[2]), .busy(bz[2]), .err(er[2]));

    function automatic int dep(input int i);
        return (i == 1) ? 200 : 256;
    endfunction
    function automatic bit rdw_new(input int i);
        return (i == 1);
    endfunction
    function automatic bit clr_en(input int i);
        return (i != 2);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: words cleared so far, memory image with known flags, expected outputs.
    int         m_cnt [3];
    logic [7:0] m_mem [3][256];
    bit         m_kn  [3][256];
    logic [7:0] e_do  [3];
    bit         e_dk  [3];
    bit         e_rv  [3];
    bit         e_er  [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_cnt[i] = clr_en(i) ? 0 : dep(i);
                e_do[i]  = 8'h00;
                e_dk[i]  = 1'b1;
                e_rv[i]  = 1'b0;
                e_er[i]  = 1'b0;
            end else if (m_cnt[i] < dep(i)) begin
                m_mem[i][m_cnt[i]] = 8'h00;
                m_kn[i][m_cnt[i]]  = 1'b1;
                m_cnt[i]++;
                e_rv[i] = 1'b0;
                e_er[i] = 1'b0;
            end else begin
                automatic int a = int'(addr);
                e_rv[i] = re;
                e_er[i] = (we || re) && (a >= dep(i));
                if (a >= dep(i)) begin
                    if (re) begin
                        e_do[i] = 8'h00;
                        e_dk[i] = 1'b1;
                    end
                end else begin
                    if (re) begin
                        if (we && rdw_new(i)) begin
                            e_do[i] = din;
                            e_dk[i] = 1'b1;
                        end else begin
                            e_do[i] = m_mem[i][a];
                            e_dk[i] = m_kn[i][a];
                        end
                    end
                    if (we) begin
                        m_mem[i][a] = din;
                        m_kn[i][a]  = 1'b1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                chk($sformatf("rst_busy%0d", i), 32'(bz[i]), 32'(clr_en(i)));
                chk($sformatf("rst_rvalid%0d", i), 32'(rv[i]), 32'd0);
                chk($sformatf("rst_err%0d", i), 32'(er[i]), 32'd0);
                chk($sformatf("rst_dout%0d", i), 32'(dout[i]), 32'd0);
            end else begin
                chk($sformatf("busy%0d", i), 32'(bz[i]), 32'(m_cnt[i] < dep(i)));
                chk($sformatf("rvalid%0d", i), 32'(rv[i]), 32'(e_rv[i]));
                chk($sformatf("err%0d", i), 32'(er[i]), 32'(e_er[i]));
                if (e_dk[i])
                    chk($sformatf("dout%0d", i), 32'(dout[i]), 32'(e_do[i]));
            end
        end
    end

    task automatic req(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
        we   = w;
        re   = r;
        addr = a;
        din  = d;
        @(posedge clk);
        #2;
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        idle(3);
        chk("lit_rst_busy0", 32'(bz[0]), 32'd1);
        chk("lit_rst_busy2", 32'(bz[2]), 32'd0);
        chk("lit_rst_rv",    32'(rv),    32'd0);
        chk("lit_rst_dout0", 32'(dout[0]), 32'd0);

        // No-clear instance: write at edge 1, read at edge 2.
        rst_n = 1'b1;
        req(1'b1, 1'b0, 8'h10, 8'hA5);
        req(1'b0, 1'b1, 8'h10, 8'h00);
        chk("lit_noclr_dout", 32'(dout[2]), 32'hA5);
        chk("lit_noclr_rv",   32'(rv[2]),   32'd1);
        chk("lit_clr_no_rv0", 32'(rv[0]),   32'd0);
        chk("lit_clr_no_rv1", 32'(rv[1]),   32'd0);

        // Reset at clear count 100.
        idle(98);
        rst_n = 1'b0;
        #1;
        chk("lit_midrst_dout2", 32'(dout[2]), 32'd0);
        chk("lit_midrst_busy0", 32'(bz[0]),   32'd1);
        idle(2);
        rst_n = 1'b1;

        req(1'b0, 1'b1, 8'h00, 8'h00);
        chk("lit_clr_req_rv0", 32'(rv[0]), 32'd0);
        n = 1;
        while (bz[0] === 1'b1 && n < 1000) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("lit_busy_edges", 32'(n), 32'd256);

        // Cleared contents.
        req(1'b0, 1'b1, 8'h00, 8'h00);
        chk("lit_clr00", 32'(dout[0]), 32'h00);
        chk("lit_clr00_rv", 32'(rv[0]), 32'd1);
        req(1'b0, 1'b1, 8'h7F, 8'h00);
        chk("lit_clr7F", 32'(dout[0]), 32'h00);
        req(1'b0, 1'b1, 8'hFF, 8'h00);
        chk("lit_clrFF", 32'(dout[0]), 32'h00);
        chk("lit_clrFF_err1", 32'(er[1]), 32'd1);
        chk("lit_clrFF_err0", 32'(er[0]), 32'd0);

        // Write then consecutive reads.
        req(1'b1, 1'b0, 8'h00, 8'h55);
        req(1'b1, 1'b0, 8'h01, 8'hAA);
        req(1'b1, 1'b0, 8'h02, 8'hFF);
        req(1'b0, 1'b1, 8'h00, 8'h00);
        chk("lit_rd0", 32'(dout[0]), 32'h55);
        chk("lit_rd0_rv", 32'(rv[0]), 32'd1);
        req(1'b0, 1'b1, 8'h01, 8'h00);
        chk("lit_rd1", 32'(dout[0]), 32'hAA);
        chk("lit_rd1_rv", 32'(rv[0]), 32'd1);
        req(1'b0, 1'b1, 8'h02, 8'h00);
        chk("lit_rd2", 32'(dout[0]), 32'hFF);
        chk("lit_rd2_rv", 32'(rv[0]), 32'd1);
        idle(1);
        chk("lit_hold_rv", 32'(rv[0]), 32'd0);
        chk("lit_hold_dout", 32'(dout[0]), 32'hFF);

        // Read-during-write on address 03.
        req(1'b1, 1'b1, 8'h03, 8'h12);
        chk("lit_rdw_old", 32'(dout[0]), 32'h00);
        chk("lit_rdw_new", 32'(dout[1]), 32'h12);
        req(1'b0, 1'b1, 8'h03, 8'h00);
        chk("lit_rdw_after0", 32'(dout[0]), 32'h12);
        chk("lit_rdw_after1", 32'(dout[1]), 32'h12);

        // Out of range on DEPTH=200; in range on DEPTH=256.
        req(1'b1, 1'b0, 8'hC8, 8'h77);
        chk("lit_oor_wr_err1", 32'(er[1]), 32'd1);
        chk("lit_oor_wr_err0", 32'(er[0]), 32'd0);
        chk("lit_oor_wr_rv1",  32'(rv[1]), 32'd0);
        req(1'b0, 1'b1, 8'hC8, 8'h00);
        chk("lit_oor_rd_err1",  32'(er[1]),   32'd1);
        chk("lit_oor_rd_rv1",   32'(rv[1]),   32'd1);
        chk("lit_oor_rd_dout1", 32'(dout[1]), 32'h00);
        chk("lit_oor_rd_dout0", 32'(dout[0]), 32'h77);
        req(1'b0, 1'b1, 8'h00, 8'h00);
        chk("lit_oor_keep00", 32'(dout[1]), 32'h55);
        chk("lit_oor_keep_err", 32'(er[1]), 32'd0);

        // Last in-range word of DEPTH=200.
        req(1'b1, 1'b0, 8'hC7, 8'h5A);
        req(1'b0, 1'b1, 8'hC7, 8'h00);
        chk("lit_last_dout1", 32'(dout[1]), 32'h5A);
        chk("lit_last_err1",  32'(er[1]),   32'd0);

        // Array survives reset on the no-clear instance.
        req(1'b0, 1'b1, 8'h10, 8'h00);
        chk("lit_keep10", 32'(dout[2]), 32'hA5);

        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_ram_param

// File: doc/ram_param.md
# ram_param

Parametrised single-port synchronous RAM for the 8-bit CPU data path. It succeeds the fixed 8×256 `ram` and adds:

- configurable width and depth;
- a registered read with a valid strobe;
- a selectable read-during-write policy;
- out-of-range address detection;
- a post-reset clear sequencer that zero-fills the array while signalling busy.

It sits between the CPU load/store unit and the data bus.

## Interface

One clock; reset is asynchronous and active-low.

Parameters:
- `DATA_W`, default 8: word width in bits.
- `ADDR_W`, default 8: address width in bits.
- `DEPTH`, default 256: number of words. Must satisfy 1 ≤ DEPTH ≤ 2^ADDR_W.
- `RDW_MODE`, default 0: read-during-write policy for the same address. 0 = old data (read-first); 1 = new data (write-first).
- `CLEAR_ON_RESET`, default 1: 1 = zero-fill the array after reset; 0 = array contents are undefined after reset.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `addr`  in  ADDR_W: word address.
- `we`  in  1: write enable, sampled at the rising edge.
- `re`  in  1: read enable, sampled at the rising edge.
- `data_in`  in  DATA_W: write data.
- `data_out`  out  DATA_W: registered read data.
- `rvalid`  out  1: one-cycle pulse; `data_out` was updated by a read.
- `busy`  out  1: clear sequence in progress; requests are ignored while high.
- `err`  out  1: one-cycle pulse; the request used `addr` ≥ DEPTH.

## Operation

State machine, two states:
- **CLEAR**
  - Entered on reset when CLEAR_ON_RESET=1.
  - A counter `clr_addr` runs 0..DEPTH-1 and writes 0 to one word per cycle.
  - After writing DEPTH-1, the FSM moves to READY.
  - `we`, `re` and `addr` are ignored in this state. No `rvalid` and no `err` are produced.
- **READY**
  - Entered on reset when CLEAR_ON_RESET=0.
  - Accepts requests every cycle.

Write: when `we`=1 and `addr` < DEPTH, `mem[addr]` ← `data_in` at the edge.

Read: when `re`=1 and `addr` < DEPTH, at the edge:
- `data_out` ← `mem[addr]`;
- `rvalid`=1 for the following cycle.

Read-during-write, same address (`we`=`re`=1):
- RDW_MODE=0 returns the previous contents.
- RDW_MODE=1 returns `data_in`.
- The write always happens.

Out-of-range (`addr` ≥ DEPTH) with `we` or `re` set:
- A write is dropped.
- A read loads `data_out` ← 0 and still pulses `rvalid`.
- `err` pulses for one cycle.

When no read occurs, `data_out` holds its last value.

Reset asserted mid-operation (including mid-CLEAR):
- all outputs go to their reset values immediately;
- when CLEAR_ON_RESET=1, the clear restarts from address 0.

The array itself is never reset directly.

## Timing

Reset values:
- `data_out`=0, `rvalid`=0, `err`=0.
- `busy`=CLEAR_ON_RESET.
- `clr_addr`=0.

Read latency is 1 cycle: a request at edge N gives `data_out` and `rvalid` valid after edge N, for the cycle between edges N and N+1.

Write takes effect at the sampling edge. A read of the same address at the next edge returns the new data.

Clear duration:
- The first clear write is at the first rising edge after `rst_n` deasserts.
- `busy` falls after the DEPTH-th edge.
- The first request accepted is the one sampled at edge DEPTH+1.

`rvalid` and `err` are registered. No output depends combinationally on any input.

## Structure

Shared package `ram_pkg` holds:
- the state enum `ram_state_t` {CLEAR, READY};
- constants `RDW_OLD`=0 and `RDW_NEW`=1.

The clear counter plus FSM is a natural sub-module, `ram_clear_fsm`. Its inputs are `clk`, `rst_n` and `enable`; its outputs are `busy`, `clr_we` and `clr_addr`.

The memory array and read register stay in the top module.

## Test plan

1. **Clear.** DATA_W=8, DEPTH=256, CLEAR_ON_RESET=1. Release reset.
   - Required: `busy`=1 for exactly 256 edges.
   - Required: after `busy` falls, reads of addresses 00, 7F and FF all return 00 with `rvalid`=1.
2. **Write/read.** Write 55 to address 00, AA to 01, FF to 02. Read 00, 01, 02 on consecutive cycles.
   - Required: `data_out` = 55, AA, FF, one cycle after each request.
   - Required: `rvalid` high for 3 consecutive cycles.
3. **Read-during-write.** Address 03 holds 00. Apply `we`=`re`=1, `addr`=03, `data_in`=12.
   - RDW_MODE=0: `data_out`=00.
   - RDW_MODE=1: `data_out`=12.
   - Both modes: a following read of 03 returns 12.
4. **Out of range.** DEPTH=200. Write 77 to address C8, then read C8.
   - Required: `err` pulses on both requests.
   - Required: the read gives `data_out`=00 with `rvalid`=1.
   - Required: address 00 is unchanged.
5. **Reset during clear.** Assert `rst_n`=0 at clear count 100, then release.
   - Required: `busy` stays high for a further 256 edges from the release.
   - Required: a request issued during clear produces no `rvalid`.
6. **No clear.** CLEAR_ON_RESET=0.
   - Required: `busy`=0 out of reset.
   - Required: a write followed by a read at edges 1 and 2 returns the written value.
